// File: rtl/a2d_spi_resp.sv
// SPI responder standing in for an 8-channel A2D: decodes 16-bit command frames
// and shifts back the channel value captured at the close of the previous frame.
`default_nettype none

module a2d_spi_resp #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SS_n,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  input  logic [8*DATA_W-1:0] chnl_vals,
  output logic                cmd_vld,
  output logic [2:0]          chnl,
  output logic                frm_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_d, sclk_d;
  logic [15:0]            shft;
  logic [4:0]             bit_cnt;
  logic [DATA_W-1:0]      result;
  logic [DATA_W-1:0]      vals [8];

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise;

  for (genvar k = 0; k < 8; k++) begin : g_unpack
    assign vals[k] = chnl_vals[k*DATA_W +: DATA_W];
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      // SS_n chain resets low so a select still held low after reset is not
      // mistaken for a fresh falling edge.
      ss_sync   <= '0;
      ss_d      <= 1'b0;
      sclk_sync <= '1;
      sclk_d    <= 1'b1;
      mosi_sync <= '0;
      state     <= IDLE;
      shft      <= '0;
      bit_cnt   <= '0;
      result    <= '0;
      chnl      <= '0;
      cmd_vld   <= 1'b0;
      frm_err   <= 1'b0;
      MISO      <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
      cmd_vld   <= 1'b0;
      frm_err   <= 1'b0;
      MISO      <= (state == ACTIVE) ? shft[15] : 1'b0;

      case (state)
        IDLE: begin
          if (ss_fall) begin
            shft    <= {{(16-DATA_W){1'b0}}, result};
            bit_cnt <= '0;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          // Frame close takes priority over a coincident SCLK rise.
          if (ss_rise) begin
            state <= IDLE;
            if (bit_cnt == 5'd16) begin
              chnl    <= shft[13:11];
              result  <= vals[shft[13:11]];
              cmd_vld <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            shft <= {shft[14:0], mosi_s};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
- Synthesizable SPI responder that emulates the 8-channel 12-bit A2D converter on the far end of the A2D SPI link.
- Receives 16-bit command frames from the A2D SPI initiator and returns the conversion result of the channel requested in the previous frame.
- Channel values come from a parallel input bus. The block serves as the A2D stand-in for full-chip benches and FPGA loopback builds.

Parameters:
- SYNC_STAGES, 2, number of flops in each synchronizer on SS_n/SCLK/MOSI (legal 2..3)
- DATA_W, 12, width of each channel value

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- SS_n  in  1  active-low slave select from initiator
- SCLK  in  1  SPI clock from initiator; idles high
- MOSI  in  1  serial command from initiator, MSB first
- MISO  out  1  serial result to initiator, MSB first
- chnl_vals  in  8*DATA_W  flat channel values; channel k occupies bits [k*DATA_W +: DATA_W]
- cmd_vld  out  1  one-clk pulse: legal 16-bit frame completed
- chnl  out  3  channel decoded from the last legal frame
- frm_err  out  1  one-clk pulse: frame closed with bit count != 16

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Input synchronizers:
  - SS_n, SCLK and MOSI each pass through SYNC_STAGES flops.
  - One extra flop per signal provides edge detect.
  - All decisions below use these synchronized signals.
- Reset values:
  - State = IDLE; shft = 0; bit_cnt = 0; result = 0.
  - chnl = 0; cmd_vld = 0; frm_err = 0; MISO = 0.
- FSM IDLE:
  - MISO = 0.
  - On SS_n falling edge: shft <= {4'b0, result}, bit_cnt <= 0, go to ACTIVE.
  - SCLK edges are ignored while in IDLE.
- FSM ACTIVE:
  - MISO = shft[15] (registered/combinational from the register; no tristate).
  - On each SCLK rising edge: shft <= {shft[14:0], MOSI_sync}; bit_cnt <= bit_cnt+1, saturating at 31.
  - SCLK falling edges have no effect.
  - On SS_n rising edge, go to IDLE and evaluate the frame:
    - bit_cnt == 16: chnl <= shft[13:11]; result <= chnl_vals[shft[13:11]], sampled this cycle; cmd_vld pulses 1 clk.
    - Any other bit_cnt, including 0: frm_err pulses 1 clk; chnl and result are unchanged.
- Simultaneous events:
  - SCLK rising edge and SS_n rising edge detected in the same clk: the SS_n rise wins and the SCLK edge is not counted.
  - SS_n falling edge in the same clk as a pending close cannot occur, because IDLE is required for a fall.
- Latency:
  - First MISO bit is valid SYNC_STAGES+2 clks after the SS_n pin falls; the initiator's front porch must be at least this.
  - Each new MISO bit is valid SYNC_STAGES+2 clks after the SCLK rise.
  - The SCLK half-period must be at least SYNC_STAGES+3 clks.
- Response timing: the result returned in frame N is the value of the channel commanded in frame N-1, sampled at the close of frame N-1. The first frame after reset returns 0.
- Command-word bits other than [13:11] are ignored.
- rst asserted mid-frame returns the block to IDLE with reset values. If SS_n is still low when rst is released, that partial frame is ignored until SS_n rises then falls again; the rise in IDLE produces no pulse.
- Width rule: result is DATA_W bits, zero-extended on the MSB side into 16 bits. DATA_W must be 12 or less.

Test Plan:
- Reset, then frame cmd 0x0800 with chnl_vals[ch1] = 0xABC → MISO returns 0x0000; at close, cmd_vld = 1 for one clk and chnl = 1.
- Second frame cmd 0x2000 with ch4 = 0x123 → MISO shifts out 0x0ABC; chnl = 4 at close; a third frame returns 0x0123.
- ch1 changes from 0xABC to 0x555 after frame 1 closes, before frame 2 → frame 2 still returns 0x0ABC (sampled at close).
- Frame with 15 SCLK rises, then one with 17 → frm_err pulses once per frame, cmd_vld stays 0, chnl is unchanged, and the next legal frame returns the prior result.
- Assert rst after 8 SCLK rises with SS_n low, release it, complete the edges, raise SS_n → no cmd_vld or frm_err; MISO = 0; the next full frame returns 0x0000.
- SS_n rise coincident with a 17th SCLK rise after 16 good bits → cmd_vld = 1 and frm_err = 0 (edge ignored); SCLK toggling with SS_n high → no state change.
